// File: rtl/tx_arbiter.sv
// tx_arbiter: packet-level arbiter in front of a byte-wide PHY transmitter.
// Locks one requester per packet and enforces idle bit times after EOP.
module tx_arbiter #(
  parameter int N_REQ    = 3,
  parameter int GAP_BITS = 2,
  parameter int PRIO0    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clk_gate_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               tx_valid_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_ready_i,
  input  logic               tx_en_i,
  output logic               busy_o
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    WAIT_EOP,
    GAP
  } state_t;

  state_t           state;
  logic [3:0]       gap_cnt;
  logic [IW-1:0]    last;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_rr;

  // winner: requester 0 on priority, else first valid above last winner
  always_comb begin
    logic          found;
    logic [IW-1:0] ix;
    int            sum;
    found    = 1'b0;
    ix       = '0;
    sum      = 0;
    pick     = '0;
    pick_idx = last;
    pick_rr  = 1'b0;
    if (PRIO0 == 1 && req_valid_i[0]) begin
      pick[0] = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        sum = int'(last) + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        ix = IW'(sum);
        if (!found && req_valid_i[ix]) begin
          found    = 1'b1;
          pick[ix] = 1'b1;
          pick_idx = ix;
          pick_rr  = 1'b1;
        end
      end
    end
  end

  // packet FSM; only reset acts off the bit-time strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant_o <= '0;
      gap_cnt <= '0;
      last    <= IW'(N_REQ - 1);
      busy_o  <= 1'b0;
    end else if (clk_gate_i) begin
      unique case (state)
        IDLE: begin
          if (|req_valid_i) begin
            grant_o <= pick;
            if (pick_rr) last <= pick_idx;
            state   <= PKT;
            busy_o  <= 1'b1;
          end
        end
        PKT: begin
          if (!(|(grant_o & req_valid_i))) state <= WAIT_EOP;
        end
        WAIT_EOP: begin
          if (!tx_en_i) begin
            if (GAP_BITS == 0) begin
              state   <= IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
            end else begin
              gap_cnt <= 4'(GAP_BITS - 1);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // byte path from the granted requester while its packet is open
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    if (state == PKT) begin
      tx_valid_o  = |(grant_o & req_valid_i);
      req_ready_o = grant_o & {N_REQ{tx_ready_i}};
      for (int k = 0; k < N_REQ; k++) begin
        if (grant_o[k]) tx_data_o = tx_data_o | req_data_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: two tx_arbiter instances (round-robin/gap 2, prio0/gap 0)
// checked every cycle against a packet-level model, plus directed scenarios.
module tb_tx_arbiter;

  localparam int N = 3;
  localparam int S_IDLE = 0;
  localparam int S_PKT  = 1;
  localparam int S_EOP  = 2;
  localparam int S_GAP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic gate;
  logic [N-1:0]   valid [2];
  logic [8*N-1:0] data [2];
  logic           tx_ready [2];
  logic           tx_en [2];
  logic [N-1:0]   ready [2];
  logic [N-1:0]   grant [2];
  logic           tx_valid [2];
  logic [7:0]     tx_data [2];
  logic           busy [2];

  always #5 clk = ~clk;

  tx_arbiter #(.N_REQ(N), .GAP_BITS(2), .PRIO0(0)) u0 (
    .clk_i(clk), .rst_i(rst), .clk_gate_i(gate),
    .req_valid_i(valid[0]), .req_data_i(data[0]),
    .req_ready_o(ready[0]), .grant_o(grant[0]),
    .tx_valid_o(tx_valid[0]), .tx_data_o(tx_data[0]),
    .tx_ready_i(tx_ready[0]), .tx_en_i(tx_en[0]),
    .busy_o(busy[0])
  );

  tx_arbiter #(.N_REQ(N), .GAP_BITS(0), .PRIO0(1)) u1 (
    .clk_i(clk), .rst_i(rst), .clk_gate_i(gate),
    .req_valid_i(valid[1]), .req_data_i(data[1]),
    .req_ready_o(ready[1]), .grant_o(grant[1]),
    .tx_valid_o(tx_valid[1]), .tx_data_o(tx_data[1]),
    .tx_ready_i(tx_ready[1]), .tx_en_i(tx_en[1]),
    .busy_o(busy[1])
  );

  function automatic int gap_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int prio_of(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // model state: phase, owner (-1 none), last round-robin winner
  int st [2];
  int own [2];
  int last [2];
  int rel [2];
  int eop_at [2];
  int idle_first [2];
  int gedge;
  int plen [2][N];
  int ppos [2][N];
  logic [7:0] pb [2][N][8];
  int glog [2][16];
  int gdif [2][16];
  int gn [2];
  bit auto_req, auto_phy, auto_gate, auto_rst;
  int ncmp, nerr;
  logic [7:0] obs [4];
  int nobs, rdy2, rdy1;
  bit after_seen;
  logic txv_after;

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
               nm, d, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      st[d]   = S_IDLE;
      own[d]  = -1;
      last[d] = N - 1;
    end
  endfunction

  function automatic int pick(int d);
    int i;
    if (prio_of(d) == 1 && valid[d][0]) return 0;
    for (int k = 1; k <= N; k++) begin
      i = (last[d] + k) % N;
      if (valid[d][i]) begin
        last[d] = i;
        return i;
      end
    end
    return -1;
  endfunction

  function automatic void go_idle(int d);
    st[d]  = S_IDLE;
    own[d] = -1;
    if (idle_first[d] < 0) idle_first[d] = gedge - eop_at[d];
  endfunction

  function automatic void advance(int d);
    int o;
    o = own[d];
    case (st[d])
      S_IDLE: begin
        if (|valid[d]) begin
          own[d] = pick(d);
          st[d]  = S_PKT;
          if (gn[d] < 16) begin
            glog[d][gn[d]] = 1 << own[d];
            gdif[d][gn[d]] = gedge - eop_at[d];
            gn[d]++;
          end
        end
      end
      S_PKT: begin
        if (tx_ready[d] && valid[d][o]) ppos[d][o]++;
        if (!valid[d][o]) st[d] = S_EOP;
      end
      S_EOP: begin
        if (!tx_en[d]) begin
          eop_at[d] = gedge;
          rel[d]    = gedge + gap_of(d);
          if (gap_of(d) == 0) go_idle(d);
          else st[d] = S_GAP;
        end
      end
      S_GAP: begin
        if (gedge == rel[d]) go_idle(d);
      end
      default: ;
    endcase
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] eg, er;
      logic ev;
      logic [7:0] ed;
      int o;
      o  = own[d];
      eg = '0;
      er = '0;
      ev = 1'b0;
      ed = 8'h00;
      if (o >= 0) eg = N'(1 << o);
      if (st[d] == S_PKT) begin
        ev = valid[d][o];
        ed = data[d][8*o +: 8];
        er = eg & {N{tx_ready[d]}};
      end
      chk("grant", d, 32'(grant[d]), 32'(eg));
      chk("busy", d, 32'(busy[d]), 32'(st[d] != S_IDLE));
      chk("tx_valid", d, 32'(tx_valid[d]), 32'(ev));
      chk("tx_data", d, 32'(tx_data[d]), 32'(ed));
      chk("req_ready", d, 32'(ready[d]), 32'(er));
    end
  endtask

  task automatic capture();
    if (ready[0][1] && grant[0] != 3'b010) rdy1++;
    if (gate && !rst) begin
      if (rdy2 == 2 && !after_seen) begin
        after_seen = 1'b1;
        txv_after  = tx_valid[0];
      end
      if (tx_valid[0] && tx_ready[0] && nobs < 4) begin
        obs[nobs] = tx_data[0];
        nobs++;
      end
      if (ready[0][2]) rdy2++;
    end
  endtask

  function automatic void load(int d, int k, int len);
    plen[d][k] = len;
    ppos[d][k] = 0;
    for (int i = 0; i < 8; i++) pb[d][k][i] = 8'($urandom);
  endfunction

  task automatic drive();
    int o;
    if (auto_gate) gate = ($urandom % 3) == 0;
    if (auto_rst) rst = ($urandom % 400) == 0;
    for (int d = 0; d < 2; d++) begin
      if (auto_req) begin
        for (int k = 0; k < N; k++) begin
          if (ppos[d][k] >= plen[d][k] && own[d] != k && ($urandom % 6) == 0)
            load(d, k, 1 + int'($urandom % 4));
        end
      end
      for (int k = 0; k < N; k++) begin
        valid[d][k] = ppos[d][k] < plen[d][k];
        data[d][8*k +: 8] = valid[d][k] ? pb[d][k][ppos[d][k]] : 8'($urandom);
      end
      if (auto_phy) begin
        tx_ready[d] = ($urandom % 4) != 0;
        tx_en[d]    = ($urandom % 3) != 0;
      end else begin
        o = own[d];
        tx_ready[d] = st[d] == S_PKT && o >= 0 && ppos[d][o] < plen[d][o];
        tx_en[d]    = st[d] != S_EOP;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    capture();
    if (rst) model_reset();
    else if (gate) begin
      gedge++;
      for (int d = 0; d < 2; d++) advance(d);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit quiet();
    quiet = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (st[d] != S_IDLE) quiet = 1'b0;
      for (int k = 0; k < N; k++)
        if (ppos[d][k] < plen[d][k]) quiet = 1'b0;
    end
  endfunction

  task automatic run_idle(int maxn, string nm);
    int n;
    n = 0;
    while (!quiet() && n < maxn) begin
      step();
      n++;
    end
    if (!quiet()) begin
      ncmp++;
      nerr++;
      $display("FAIL %s: not idle after %0d cycles, expected idle", nm, maxn);
    end
  endtask

  initial begin
    ncmp = 0; nerr = 0; gedge = 0;
    rst = 1'b1; gate = 1'b0;
    auto_req = 0; auto_phy = 0; auto_gate = 0; auto_rst = 0;
    nobs = 0; rdy2 = 0; rdy1 = 0; after_seen = 0; txv_after = 1'b1;
    for (int d = 0; d < 2; d++) begin
      gn[d] = 0;
      eop_at[d] = -100;
      idle_first[d] = -1;
      for (int k = 0; k < N; k++) begin
        plen[d][k] = 0;
        ppos[d][k] = 0;
      end
    end
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_grant", d, 32'(grant[d]), 32'h0);
      chk("reset_busy", d, 32'(busy[d]), 32'h0);
      chk("reset_tx_valid", d, 32'(tx_valid[d]), 32'h0);
      chk("reset_tx_data", d, 32'(tx_data[d]), 32'h0);
      chk("reset_req_ready", d, 32'(ready[d]), 32'h0);
    end
    @(posedge clk);
    #1;
    gate = 1'b1;

    // three simultaneous 3-byte packets
    for (int d = 0; d < 2; d++) for (int k = 0; k < N; k++) load(d, k, 3);
    drive();
    run_idle(300, "all_three");
    for (int d = 0; d < 2; d++) begin
      chk("rr_count", d, 32'(gn[d]), 32'd3);
      chk("rr_g0", d, 32'(glog[d][0]), 32'h1);
      chk("rr_g1", d, 32'(glog[d][1]), 32'h2);
      chk("rr_g2", d, 32'(glog[d][2]), 32'h4);
    end

    // priority of requester 0 and its effect on last_winner
    rst = 1'b1;
    step();
    rst = 1'b0;
    gn[0] = 0;
    gn[1] = 0;
    for (int d = 0; d < 2; d++) begin
      load(d, 0, 2);
      load(d, 1, 2);
    end
    drive();
    run_idle(300, "prio_a");
    for (int d = 0; d < 2; d++) load(d, 0, 1);
    drive();
    run_idle(300, "prio_b");
    for (int d = 0; d < 2; d++) begin
      load(d, 1, 2);
      load(d, 2, 2);
    end
    drive();
    run_idle(300, "prio_c");
    chk("seq_g0", 0, 32'(glog[0][0]), 32'h1);
    chk("seq_g1", 0, 32'(glog[0][1]), 32'h2);
    chk("seq_g2", 0, 32'(glog[0][2]), 32'h1);
    chk("seq_g3", 0, 32'(glog[0][3]), 32'h2);
    chk("seq_g4", 0, 32'(glog[0][4]), 32'h4);
    chk("seq_g0", 1, 32'(glog[1][0]), 32'h1);
    chk("seq_g1", 1, 32'(glog[1][1]), 32'h2);
    chk("seq_g2", 1, 32'(glog[1][2]), 32'h1);
    chk("seq_g3", 1, 32'(glog[1][3]), 32'h4);
    chk("seq_g4", 1, 32'(glog[1][4]), 32'h2);

    // two-byte packet A5, 3C from requester 2
    nobs = 0;
    rdy2 = 0;
    after_seen = 0;
    for (int d = 0; d < 2; d++) begin
      load(d, 2, 2);
      pb[d][2][0] = 8'hA5;
      pb[d][2][1] = 8'h3C;
    end
    drive();
    run_idle(300, "two_byte");
    chk("bytes_sent", 0, 32'(nobs), 32'd2);
    chk("byte0", 0, 32'(obs[0]), 32'hA5);
    chk("byte1", 0, 32'(obs[1]), 32'h3C);
    chk("ready2_pulses", 0, 32'(rdy2), 32'd2);
    chk("tx_valid_after", 0, 32'(txv_after), 32'h0);

    // late request during packet, gap timing after EOP
    gn[0] = 0;
    gn[1] = 0;
    rdy1 = 0;
    idle_first[0] = -1;
    idle_first[1] = -1;
    for (int d = 0; d < 2; d++) load(d, 0, 3);
    drive();
    repeat (3) step();
    for (int d = 0; d < 2; d++) load(d, 1, 2);
    drive();
    run_idle(300, "late_req");
    chk("late_g0", 0, 32'(glog[0][0]), 32'h1);
    chk("late_g1", 0, 32'(glog[0][1]), 32'h2);
    chk("gap_grant_edge", 0, 32'(gdif[0][1]), 32'd3);
    chk("gap_grant_edge", 1, 32'(gdif[1][1]), 32'd1);
    chk("gap_idle_edge", 0, 32'(idle_first[0]), 32'd2);
    chk("gap_idle_edge", 1, 32'(idle_first[1]), 32'd0);
    chk("ready1_leak", 0, 32'(rdy1), 32'd0);

    // reset mid-packet with the strobe low
    for (int d = 0; d < 2; d++) load(d, 0, 4);
    drive();
    repeat (2) step();
    gate = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midrst_tx_valid", d, 32'(tx_valid[d]), 32'h0);
      chk("midrst_grant", d, 32'(grant[d]), 32'h0);
      chk("midrst_busy", d, 32'(busy[d]), 32'h0);
    end
    @(posedge clk);
    #1;
    gate = 1'b1;
    drive();
    run_idle(300, "after_reset");

    // randomized traffic
    auto_req = 1;
    auto_phy = 1;
    auto_gate = 1;
    auto_rst = 1;
    repeat (4000) step();
    auto_rst = 0;
    auto_req = 0;
    rst = 1'b0;
    run_idle(3000, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
